// File: rtl/vec_store_serializer.sv
// rtl/vec_store_serializer.sv - writes a LANES x DATA_W vector to memory one word per cycle, lane 0 first.
// Optional per-lane address stride is enabled with VEC_STORE_STRIDE_EN.
module vec_store_serializer #(
    parameter int LANES  = 16,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [ADDR_W-1:0]         base_addr,
    input  logic [LANES*DATA_W-1:0]   vec_data,
    input  logic [4:0]                src_reg,
`ifdef VEC_STORE_STRIDE_EN
    input  logic [ADDR_W-1:0]         stride,
`endif
    output logic                      busy,
    output logic                      done,
    output logic [4:0]                done_reg,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic                      mem_ready
);

    localparam int IDX_W = $clog2(LANES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

    state_t                    state;
    logic [IDX_W-1:0]          idx;
    logic [IDX_W-1:0]          idx_next;
    logic [LANES*DATA_W-1:0]   vec_q;
    logic [4:0]                reg_q;
    logic [ADDR_W-1:0]         step;
    logic [DATA_W-1:0]         next_word;

`ifdef VEC_STORE_STRIDE_EN
    logic [ADDR_W-1:0]         stride_q;
    assign step = stride_q;
`else
    assign step = ADDR_W'(1);
`endif

    assign idx_next  = idx + IDX_W'(1);
    assign next_word = vec_q[int'(idx_next)*DATA_W +: DATA_W];

    // Address advances by accumulation so stride needs only an adder.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            vec_q     <= '0;
            reg_q     <= '0;
`ifdef VEC_STORE_STRIDE_EN
            stride_q  <= '0;
`endif
            busy      <= 1'b0;
            done      <= 1'b0;
            done_reg  <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        vec_q     <= vec_data;
                        reg_q     <= src_reg;
`ifdef VEC_STORE_STRIDE_EN
                        stride_q  <= stride;
`endif
                        idx       <= '0;
                        mem_we    <= 1'b1;
                        mem_addr  <= base_addr;
                        mem_wdata <= vec_data[DATA_W-1:0];
                        busy      <= 1'b1;
                        state     <= WRITE;
                    end
                end
                WRITE: begin
                    if (mem_ready) begin
                        if (idx == LAST_IDX) begin
                            mem_we   <= 1'b0;
                            done     <= 1'b1;
                            done_reg <= reg_q;
                            state    <= DONE;
                        end else begin
                            idx       <= idx_next;
                            mem_addr  <= mem_addr + step;
                            mem_wdata <= next_word;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vec_store_serializer.sv
// tb/tb_vec_store_serializer.sv - table-driven self-checking bench for vec_store_serializer.
module tb_vec_store_serializer;

    localparam int LANES  = 16;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     start = 1'b0;
    logic [ADDR_W-1:0]        base_addr = '0;
    logic [LANES*DATA_W-1:0]  vec_data = '0;
    logic [4:0]               src_reg = '0;
    logic [ADDR_W-1:0]        stride = 16'd1;
    logic                     busy, done, mem_we;
    logic [4:0]               done_reg;
    logic [ADDR_W-1:0]        mem_addr;
    logic [DATA_W-1:0]        mem_wdata;
    logic                     mem_ready = 1'b1;

    int n_chk  = 0;
    int n_fail = 0;

    vec_store_serializer #(.LANES(LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .vec_data  (vec_data),
        .src_reg   (src_reg),
`ifdef VEC_STORE_STRIDE_EN
        .stride    (stride),
`endif
        .busy      (busy),
        .done      (done),
        .done_reg  (done_reg),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] base;
        logic [15:0] seed;
        logic [15:0] stride;
        logic [15:0] last_addr;
        logic [4:0]  src;
        int          sa;
        int          sb;
        int          exp_done;
        bit          poke;
    } rec_t;

    rec_t tbl[8];
    int   ntbl;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Lane i carries seed+i; stall lanes sa/sb are held off for two cycles each.
    task automatic run_store(input rec_t r);
        int acc = 0, sca = 0, scb = 0, done_k = -1, writes = 0;
        logic rdy;
        logic [15:0] exp_addr;
        logic [LANES*DATA_W-1:0] v;
        @(negedge clk);
        for (int i = 0; i < LANES; i++) v[i*DATA_W +: DATA_W] = r.seed + 16'(i);
        vec_data  = v;
        base_addr = r.base;
        src_reg   = r.src;
        stride    = r.stride;
        mem_ready = 1'b1;
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (r.poke && k == 4) begin
                start     = 1'b1;
                base_addr = 16'h5555;
                vec_data  = ~v;
            end else if (r.poke && k == 5) begin
                start = 1'b0;
            end
            if (done_k >= 0 && k == done_k + 1) begin
                chk("done_one_cycle", {31'd0, done}, 32'd0);
                chk("busy_after_done", {31'd0, busy}, 32'd0);
                break;
            end
            if (mem_we) begin
                exp_addr = r.base + r.stride * 16'(acc);
                chk("mem_addr", {16'd0, mem_addr}, {16'd0, exp_addr});
                chk("mem_wdata", {16'd0, mem_wdata}, {16'd0, r.seed + 16'(acc)});
                chk("busy_writing", {31'd0, busy}, 32'd1);
                if (acc == LANES - 1)
                    chk("last_addr", {16'd0, mem_addr}, {16'd0, r.last_addr});
            end
            if (done) begin
                done_k = k;
                chk("done_reg", {27'd0, done_reg}, {27'd0, r.src});
                chk("lanes_written", writes, LANES);
                chk("busy_at_done", {31'd0, busy}, 32'd1);
            end
            rdy = 1'b1;
            if (mem_we && acc == r.sa && sca < 2) begin
                rdy = 1'b0;
                sca++;
            end else if (mem_we && acc == r.sb && scb < 2) begin
                rdy = 1'b0;
                scb++;
            end
            mem_ready = rdy;
            if (mem_we && rdy) begin
                acc++;
                writes++;
            end
        end
        chk("done_cycle", done_k, r.exp_done);
        mem_ready = 1'b1;
        if (r.poke) begin
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                chk("no_second_store", {30'd0, mem_we, busy}, 32'd0);
            end
        end
    endtask

    initial begin
        int bad;
        rec_t rr;
        ntbl = 0;
        tbl[ntbl++] = '{16'h0100, 16'hA000, 16'd1, 16'h010F, 5'd5,  99, 99, 16, 1'b0};
        tbl[ntbl++] = '{16'h0100, 16'hA000, 16'd1, 16'h010F, 5'd5,  3,  10, 20, 1'b0};
        tbl[ntbl++] = '{16'hFFFC, 16'h1230, 16'd1, 16'h000B, 5'd31, 99, 99, 16, 1'b0};
        tbl[ntbl++] = '{16'h0000, 16'hFFF8, 16'd1, 16'h000F, 5'd0,  0,  15, 20, 1'b0};
        tbl[ntbl++] = '{16'h0200, 16'h4000, 16'd1, 16'h020F, 5'd17, 99, 99, 16, 1'b1};
`ifdef VEC_STORE_STRIDE_EN
        tbl[ntbl++] = '{16'h0010, 16'hB000, 16'd4, 16'h004C, 5'd9,  99, 99, 16, 1'b0};
        tbl[ntbl++] = '{16'h0010, 16'hC000, 16'd0, 16'h0010, 5'd10, 5,  99, 18, 1'b0};
`endif

        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_done_reg", {27'd0, done_reg}, 32'd0);
        chk("reset_mem_we", {31'd0, mem_we}, 32'd0);
        chk("reset_mem_addr", {16'd0, mem_addr}, 32'd0);
        chk("reset_mem_wdata", {16'd0, mem_wdata}, 32'd0);
        rst = 1'b0;

        for (int t = 0; t < ntbl; t++) run_store(tbl[t]);

        // Abort after 7 accepted lanes, then confirm a clean restart.
        @(negedge clk);
        for (int i = 0; i < LANES; i++) vec_data[i*DATA_W +: DATA_W] = 16'h3000 + 16'(i);
        base_addr = 16'h0300;
        src_reg   = 5'd3;
        stride    = 16'd1;
        mem_ready = 1'b1;
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (8) @(negedge clk);
        chk("pre_reset_addr", {16'd0, mem_addr}, 32'h0307);
        rst = 1'b1;
        #1;
        chk("abort_mem_we", {31'd0, mem_we}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done || mem_we) bad++;
        end
        chk("no_activity_after_abort", bad, 0);
        rr = '{16'h0400, 16'h7000, 16'd1, 16'h040F, 5'd7, 99, 99, 16, 1'b0};
        run_store(rr);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
